// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN,
    BODY,
    ACK,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [7:0] LOADER_ACK_BYTE = 8'haa;

endpackage

// File: rtl/byte_packer.sv
// 8->32 little-endian word assembler; out_valid/out_word are combinational on the 4th byte.
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clear,
  output logic        out_valid,
  output logic [31:0] out_word
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;

  // Outputs are kept apart from the next-state logic so clear (derived from out_valid upstream) forms no loop.
  assign out_valid = in_valid && (idx_q == 2'd3);
  assign out_word  = {in_data, buf_q};

  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (in_valid) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    buf_d[7:0]   = in_data;
        2'd1:    buf_d[15:8]  = in_data;
        2'd2:    buf_d[23:16] = in_data;
        default: ;
      endcase
    end
    if (clear) begin
      idx_d = '0;
      buf_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Parses a length header from the UART byte stream, pushes that many 32-bit words,
// then returns one acknowledge byte and raises done.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] INSTR_MEM_SIZE = 32'h8000,
  parameter logic [7:0]  ACK_BYTE       = LOADER_ACK_BYTE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        push,
  output logic [31:0] push_data,
  output logic        loading,
  output logic        done,
  output logic        error
);

  loader_state_t state_q, state_d;
  logic [31:0]   length_q, length_d;
  logic [31:0]   word_count_q, word_count_d;
  logic          push_q, push_d;
  logic [31:0]   push_data_q, push_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          loading_q, loading_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          pk_in_valid;
  logic          pk_clear;
  logic          pk_valid;
  logic [31:0]   pk_word;

  assign pk_in_valid = rx_valid && ((state_q == LEN) || (state_q == BODY));
  assign pk_clear    = (state_d != state_q);

  byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (pk_in_valid),
    .in_data   (rx_data),
    .clear     (pk_clear),
    .out_valid (pk_valid),
    .out_word  (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    word_count_d = word_count_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    case (state_q)
      LEN: begin
        if (pk_valid) begin
          length_d = pk_word;
          if (pk_word == '0)                  state_d = ACK;
          else if (pk_word > INSTR_MEM_SIZE)  state_d = ERROR;
          else                                state_d = BODY;
        end
      end
      BODY: begin
        if (pk_valid) begin
          push_d       = 1'b1;
          push_data_d  = pk_word;
          word_count_d = word_count_q + 32'd1;
          if (word_count_q + 32'd1 == length_q) state_d = ACK;
        end
      end
      ACK: begin
        if (tx_valid_q && tx_ready) state_d = DONE;
      end
      default: ;
    endcase
    // After a body load the offer waits one cycle so it follows the final push.
    tx_valid_d = (state_d == ACK) && (state_q != BODY);
    loading_d  = (state_d == BODY);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LEN;
      length_q     <= '0;
      word_count_q <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      tx_valid_q   <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      word_count_q <= word_count_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      tx_valid_q   <= tx_valid_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign push      = push_q;
  assign push_data = push_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = ACK_BYTE;
  assign loading   = loading_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader against a byte-stream reference model.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        push;
  logic [31:0] push_data;
  logic        loading;
  logic        done;
  logic        error;

  localparam logic [31:0] MEM_SIZE = 32'h8000;

  always #5 clock = ~clock;

  program_loader #(
    .INSTR_MEM_SIZE (MEM_SIZE),
    .ACK_BYTE       (8'haa)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .push      (push),
    .push_data (push_data),
    .loading   (loading),
    .done      (done),
    .error     (error)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: the accepted byte stream plus acknowledge bookkeeping.
  logic [7:0] m_s[$];
  bit         m_acked;
  bit         m_prev_tx;
  bit         m_prev_complete;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_hdr();
    return m_s.size() >= 4;
  endfunction

  function automatic logic [31:0] m_len();
    if (m_s.size() < 4) return '0;
    return {m_s[3], m_s[2], m_s[1], m_s[0]};
  endfunction

  function automatic bit m_err();
    return m_hdr() && (m_len() > MEM_SIZE);
  endfunction

  function automatic bit m_complete();
    longint need;
    need = 64'd4 + 64'd4 * longint'(m_len());
    return m_hdr() && !m_err() && (longint'(m_s.size()) >= need);
  endfunction

  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    bit          acc;
    bit          exp_push;
    bit          exp_tx;
    bit          cmp;
    int          n;
    logic [31:0] w;
    rx_valid = v;
    rx_data  = d;
    tx_ready = rdy;
    @(posedge clock);
    #1;
    exp_push = 1'b0;
    exp_tx   = 1'b0;
    w        = '0;
    if (reset) begin
      m_s.delete();
      m_acked         = 1'b0;
      m_prev_tx       = 1'b0;
      m_prev_complete = 1'b0;
      check_eq("push_data_rst", push_data, 32'h0);
    end else begin
      if (m_prev_tx && rdy) m_acked = 1'b1;
      acc = v && !m_err() && !m_complete();
      if (acc) begin
        m_s.push_back(d);
        n = m_s.size();
        if (n > 4 && (n % 4) == 0) begin
          exp_push = 1'b1;
          w = {m_s[n-1], m_s[n-2], m_s[n-3], m_s[n-4]};
        end
      end
      cmp = m_complete();
      exp_tx = cmp && !m_acked && ((m_len() == 0) || m_prev_complete);
      m_prev_complete = cmp;
      m_prev_tx       = exp_tx;
    end
    check_eq("push", push, exp_push);
    if (exp_push) check_eq("push_data", push_data, w);
    check_eq("tx_valid", tx_valid, exp_tx);
    check_eq("tx_data", tx_data, 32'haa);
    check_eq("loading", loading, m_hdr() && !m_err() && !m_complete());
    check_eq("done", done, m_acked);
    check_eq("error", error, m_err());
  endtask

  task automatic idle(input int unsigned n, input bit rdy);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2, 1'b0);
    reset = 1'b0;
    idle(1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
    cycle(1'b1, b, 1'b0);
    if (maxgap != 0) idle($urandom_range(0, maxgap), 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
    logic [31:0] t;
    t = w;
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(t[7:0], maxgap);
      t = t >> 8;
    end
  endtask

  task automatic finish_ack(input int unsigned hold);
    idle(hold, 1'b0);
    for (int unsigned i = 0; i < 10 && !m_acked; i++) cycle(1'b0, 8'h00, 1'b1);
    check_eq("ack_seen", {31'b0, m_acked}, 32'h1);
    idle(2, 1'b0);
  endtask

  initial begin
    logic [31:0] words[3];
    int unsigned nw;
    words[0] = 32'h11223344;
    words[1] = 32'haabbccdd;
    words[2] = 32'h00000001;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    do_reset();

    // Three words back-to-back, then stray bytes after done.
    send_word(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(words[i], 0);
    finish_ack(3);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);

    // Zero-length header.
    do_reset();
    send_word(32'd0, 0);
    finish_ack(0);

    // Oversize header: error, later bytes ignored.
    do_reset();
    send_word(32'h00008001, 0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    idle(4, 1'b1);

    // Same image with idle gaps and a slow transmitter.
    do_reset();
    send_word(32'd3, 7);
    for (int i = 0; i < 3; i++) send_word(words[i], 7);
    finish_ack(5);

    // Reset partway through the second word, then a fresh one-word load.
    do_reset();
    send_word(32'd2, 0);
    send_word(32'hcafef00d, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset();
    send_word(32'd1, 0);
    send_word(32'hdeadbeef, 2);
    finish_ack(1);

    // Exactly full memory is a legal length.
    do_reset();
    send_word(MEM_SIZE, 0);
    send_word(32'h01020304, 0);
    send_word(32'h05060708, 1);

    // Random loads.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      nw = $urandom_range(1, 5);
      send_word(nw, 3);
      for (int unsigned i = 0; i < nw; i++) send_word($urandom, 3);
      finish_ack($urandom_range(0, 6));
      send_byte(8'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
